// File: rtl/taitosj_obj_pkg.sv
// rtl/taitosj_obj_pkg.sv - shared object-RAM types, constants and byte-lane address scramble
//
// Purpose : common definitions for the object-RAM writer (obj_ram_loader) and the
//           obj_bus CPU port, so both sides agree on the lane scramble.
// Contents: obj_ld_state_t  loader FSM state encoding
//           OBJ_RAM_AW      byte address width of one object-RAM bank
//           OBJ_HIDE_BYTE   fill value that parks a sprite off-screen (Y nibble F)
//           obj_addr_scramble(cnt) linear byte index -> physical lane address
package taitosj_obj_pkg;

  localparam int OBJ_RAM_AW = 8;
  localparam logic [7:0] OBJ_HIDE_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FILL  = 3'd4,
    ST_DONE  = 3'd5
  } obj_ld_state_t;

  // The two low address lines are swizzled on the board: bit1 = cnt1 XNOR cnt0,
  // bit0 = ~cnt0. Upper lines pass straight through.
  function automatic logic [OBJ_RAM_AW-1:0] obj_addr_scramble(input logic [OBJ_RAM_AW-1:0] cnt);
    return {cnt[OBJ_RAM_AW-1:2], cnt[1] ^ ~cnt[0], ~cnt[0]};
  endfunction

endpackage

// File: rtl/obj_ram_loader.sv
// rtl/obj_ram_loader.sv - vblank DMA copying the sprite attribute list into object RAM
//
// Purpose : once per frame, copies OBJ_BYTES bytes from CPU work RAM (via the
//           main-RAM arbiter handshake) into port B of the object RAM, writing
//           the bank opposite the one on display and applying the lane scramble.
// Macro   : OBJ_LOADER_CLEAR_EN - when defined, the remaining bytes of the bank
//           (OBJ_BYTES..255) are then filled with OBJ_HIDE_BYTE so stale sprites
//           are hidden. Undefined: the run ends right after the last copied byte.
// Ports   : clkm_48MHZ  in   sole clock, rising edge
//           reset       in   synchronous, active-high
//           start       in   level; a 0->1 edge while idle starts a run
//           src_base    in   source start address, sampled at start
//           disp_bank   in   displayed bank; the other bank is written
//           src_req     out  source read request (held until src_ack)
//           src_addr    out  source read address (base + cnt, wraps)
//           src_ack     in   one-cycle acknowledge, src_data valid with it
//           src_data    in   source read data
//           obj_addr    out  {bank, scrambled byte address}
//           obj_data    out  object RAM write data
//           obj_we      out  one-cycle write strobe
//           busy        out  run in progress; holds off CPU object writes
//           done        out  one-cycle pulse at end of run
module obj_ram_loader
  import taitosj_obj_pkg::*;
#(
  parameter int OBJ_BYTES = 128,
  parameter int SRC_AW    = 16
) (
  input  logic              clkm_48MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_base,
  input  logic              disp_bank,
  output logic              src_req,
  output logic [SRC_AW-1:0] src_addr,
  input  logic              src_ack,
  input  logic [7:0]        src_data,
  output logic [OBJ_RAM_AW:0] obj_addr,
  output logic [7:0]        obj_data,
  output logic              obj_we,
  output logic              busy,
  output logic              done
);

  // Counter is one bit wider than the lane address so OBJ_BYTES == 256 can be
  // compared without wrapping into the other bank.
  localparam logic [8:0] LP_BYTES = 9'(OBJ_BYTES);

`ifdef OBJ_LOADER_CLEAR_EN
  localparam bit LP_CLEAR = (OBJ_BYTES < 256);
`else
  localparam bit LP_CLEAR = 1'b0;
`endif

  obj_ld_state_t r_state;
  obj_ld_state_t w_next;

  logic                r_start_d;
  logic [SRC_AW-1:0]   r_base;
  logic                r_bank;
  logic [8:0]          r_cnt;
  logic                r_src_req;
  logic [SRC_AW-1:0]   r_src_addr;
  logic [OBJ_RAM_AW:0] r_obj_addr;
  logic [7:0]          r_obj_data;
  logic                r_obj_we;

  logic       w_start_edge;
  logic [8:0] w_cnt_inc;
  logic       w_last_data;
  logic       w_fill_last;
  logic       w_busy;
  logic       w_done;

  assign w_start_edge = start & ~r_start_d;
  assign w_cnt_inc    = r_cnt + 9'd1;
  assign w_last_data  = (w_cnt_inc == LP_BYTES);
  assign w_fill_last  = (r_cnt[7:0] == 8'hFF);

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_start_edge) w_next = ST_REQ;
      end
      ST_REQ:  w_next = ST_WAIT;
      ST_WAIT: if (src_ack) w_next = ST_WRITE;
      ST_WRITE: begin
        if (w_last_data) w_next = LP_CLEAR ? ST_FILL : ST_DONE;
        else             w_next = ST_REQ;
      end
`ifdef OBJ_LOADER_CLEAR_EN
      ST_FILL: if (w_fill_last) w_next = ST_DONE;
`endif
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkm_48MHZ) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      // Track start even in reset so a level held high through reset is not an edge.
      r_start_d  <= start;
      r_base     <= '0;
      r_bank     <= 1'b0;
      r_cnt      <= '0;
      r_src_req  <= 1'b0;
      r_src_addr <= '0;
      r_obj_addr <= '0;
      r_obj_data <= '0;
      r_obj_we   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_d <= start;
      r_obj_we  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_base <= src_base;
            r_bank <= ~disp_bank;
            r_cnt  <= '0;
          end
        end
        ST_REQ: begin
          r_src_req  <= 1'b1;
          r_src_addr <= r_base + SRC_AW'(r_cnt);
        end
        ST_WAIT: begin
          if (src_ack) begin
            r_src_req  <= 1'b0;
            r_obj_data <= src_data;
            r_obj_addr <= {r_bank, obj_addr_scramble(r_cnt[7:0])};
            r_obj_we   <= 1'b1;
          end
        end
        ST_WRITE, ST_FILL: begin
          r_cnt <= w_cnt_inc;
          // Strobe for the next fill byte is staged here so each FILL cycle writes.
          if (w_next == ST_FILL) begin
            r_obj_data <= OBJ_HIDE_BYTE;
            r_obj_addr <= {r_bank, obj_addr_scramble(w_cnt_inc[7:0])};
            r_obj_we   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign src_req  = r_src_req;
  assign src_addr = r_src_addr;
  assign obj_addr = r_obj_addr;
  assign obj_data = r_obj_data;
  assign obj_we   = r_obj_we;
  assign busy     = w_busy;
  assign done     = w_done;

endmodule
